// File: rtl/mbist_sequencer.sv
// rtl/mbist_sequencer.sv - MBIST session sequencer driving MarchC, MarchA and APNPSF in turn
module mbist_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int WDOG_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            algo_sel,
    output logic                  marchc_en,
    output logic                  marcha_en,
    output logic                  apnpsf_en,
    input  logic                  marchc_complete,
    input  logic                  marcha_complete,
    input  logic                  apnpsf_complete,
    input  logic                  error,
    input  logic                  force_terminate,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            fail_algo,
    output logic                  aborted,
    output logic                  timeout,
    output logic [ADDR_WIDTH-1:0] error_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // The watchdog trips on the cycle it would step onto all-ones.
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = {{(WDOG_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = '1;

    state_t                  state;
    logic [2:0]              pending;
    logic [WDOG_WIDTH-1:0]   wdog;
    logic [2:0]              active;
    logic [2:0]              completes;
    logic [2:0]              lowest;
    logic                    hit;

    // Enables are one-hot and in bit order of algo_sel, so they double as the active-algorithm mask.
    assign active    = {apnpsf_en, marcha_en, marchc_en};
    assign completes = {apnpsf_complete, marcha_complete, marchc_complete};
    assign hit       = |(active & completes);

    // Isolate the lowest set pending bit: MarchC first, then MarchA, then APNPSF.
    always_comb begin
        lowest = pending & (~pending + 3'd1);
    end

    // Session control: state, enables, verdict and error bookkeeping, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= 3'b000;
            wdog        <= '0;
            marchc_en   <= 1'b0;
            marcha_en   <= 1'b0;
            apnpsf_en   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_algo   <= 3'b000;
            aborted     <= 1'b0;
            timeout     <= 1'b0;
            error_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pending     <= algo_sel;
                        fail_algo   <= 3'b000;
                        aborted     <= 1'b0;
                        timeout     <= 1'b0;
                        error_count <= '0;
                        pass        <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    wdog <= '0;
                    if (pending != 3'b000) begin
                        {apnpsf_en, marcha_en, marchc_en} <= lowest;
                        state <= RUN;
                    end else begin
                        done  <= 1'b1;
                        pass  <= (fail_algo == 3'b000) && !aborted && !timeout;
                        state <= FINISH;
                    end
                end
                RUN: begin
                    wdog <= wdog + WDOG_WIDTH'(1);
                    // Errors are charged to the running algorithm, including on its completing cycle.
                    if (error) begin
                        fail_algo <= fail_algo | active;
                        if (error_count != COUNT_MAX) begin
                            error_count <= error_count + ADDR_WIDTH'(1);
                        end
                    end
                    if (force_terminate) begin
                        aborted <= 1'b1;
                        {apnpsf_en, marcha_en, marchc_en} <= 3'b000;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= FINISH;
                    end else if (hit) begin
                        {apnpsf_en, marcha_en, marchc_en} <= 3'b000;
                        pending <= pending & ~active;
                        state   <= SELECT;
                    end else if (wdog == WDOG_LAST) begin
                        timeout <= 1'b1;
                        {apnpsf_en, marcha_en, marchc_en} <= 3'b000;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbist_sequencer.sv
// tb/tb_mbist_sequencer.sv - self-checking bench for mbist_sequencer with a decoder model
module tb_mbist_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] algo_sel = 3'b000;
    logic       marchc_en, marcha_en, apnpsf_en;
    logic       marchc_complete = 1'b0, marcha_complete = 1'b0, apnpsf_complete = 1'b0;
    logic       error = 1'b0;
    logic       force_terminate = 1'b0;
    logic       busy, done, pass, aborted, timeout;
    logic [2:0] fail_algo;
    logic [3:0] error_count;

    mbist_sequencer #(.ADDR_WIDTH(4), .WDOG_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .algo_sel(algo_sel),
        .marchc_en(marchc_en), .marcha_en(marcha_en), .apnpsf_en(apnpsf_en),
        .marchc_complete(marchc_complete), .marcha_complete(marcha_complete),
        .apnpsf_complete(apnpsf_complete), .error(error),
        .force_terminate(force_terminate), .busy(busy), .done(done), .pass(pass),
        .fail_algo(fail_algo), .aborted(aborted), .timeout(timeout),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    // Decoder behaviour: per algorithm, cycles from enable rise to complete (>14 = never),
    // cycle offset of force_terminate (-1 = none) and per-offset error pattern.
    int        dly [3];
    int        abt [3];
    bit [15:0] emask [3];
    bit        noise;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_en [0:127];
    int         exp_done;
    bit         exp_pass, exp_ab, exp_to;
    logic [2:0] exp_fail;
    int         exp_cnt;

    logic [2:0] prev_en = 3'b000;
    logic [2:0] dec_en;
    int         off = 0;
    int         k_act;

    // Decoder model: reacts to the enables observed mid-cycle, driving its flags for the next edge.
    always @(negedge clk) begin
        dec_en = {apnpsf_en, marcha_en, marchc_en};
        if (dec_en != 3'b000) begin
            if (dec_en != prev_en) off = 0;
            else off = off + 1;
            k_act = dec_en[0] ? 0 : (dec_en[1] ? 1 : 2);
            marchc_complete = (k_act == 0) ? (off == dly[0]) : (noise && ($urandom % 3 == 0));
            marcha_complete = (k_act == 1) ? (off == dly[1]) : (noise && ($urandom % 3 == 0));
            apnpsf_complete = (k_act == 2) ? (off == dly[2]) : (noise && ($urandom % 3 == 0));
            error           = (off < 16) ? emask[k_act][off] : 1'b0;
            force_terminate = (abt[k_act] == off);
        end else begin
            marchc_complete = noise && ($urandom % 3 == 0);
            marcha_complete = noise && ($urandom % 3 == 0);
            apnpsf_complete = noise && ($urandom % 3 == 0);
            error           = noise && ($urandom % 2 == 0);
            force_terminate = noise && ($urandom % 3 == 0);
        end
        prev_en = dec_en;
    end

    // Expected session, as cycle offsets from the start cycle, straight from the session rules.
    function automatic void model(input logic [2:0] sel);
        int t, endo, cnt;
        for (int i = 0; i < 128; i++) exp_en[i] = 3'b000;
        t = 2; cnt = 0; exp_fail = 3'b000; exp_ab = 0; exp_to = 0; exp_done = -1;
        for (int k = 0; k < 3; k++) begin
            if (sel[k] && exp_done < 0) begin
                endo = (dly[k] > 14) ? 14 : dly[k];
                if (abt[k] >= 0 && abt[k] <= endo) endo = abt[k];
                for (int o = 0; o <= endo; o++) begin
                    exp_en[t + o] = 3'(1 << k);
                    if (emask[k][o]) begin
                        cnt++;
                        exp_fail[k] = 1'b1;
                    end
                end
                if (abt[k] >= 0 && abt[k] == endo) begin
                    exp_ab = 1; exp_done = t + endo + 1;
                end else if (dly[k] > 14) begin
                    exp_to = 1; exp_done = t + 15;
                end else begin
                    t = t + dly[k] + 2;
                end
            end
        end
        if (exp_done < 0) exp_done = t;
        exp_cnt  = (cnt > 15) ? 15 : cnt;
        exp_pass = (exp_fail == 3'b000) && !exp_ab && !exp_to;
    endfunction

    task automatic set_cfg(input int d0, input int d1, input int d2,
                           input int a0, input int a1, input int a2,
                           input bit [15:0] e0, input bit [15:0] e1, input bit [15:0] e2);
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
        abt[0] = a0; abt[1] = a1; abt[2] = a2;
        emask[0] = e0; emask[1] = e1; emask[2] = e2;
    endtask

    // Runs one session from the current negedge, checking every cycle against the model.
    task automatic run_session(input logic [2:0] sel, input string name);
        logic [2:0] en;
        model(sel);
        start = 1'b1; algo_sel = sel;
        for (int o = 1; o <= exp_done + 1; o++) begin
            @(negedge clk);
            if (noise && o <= exp_done) begin
                start = ($urandom % 3 == 0); algo_sel = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            en = {apnpsf_en, marcha_en, marchc_en};
            n_checks++;
            if (en !== exp_en[o]) begin
                n_fail++;
                $display("FAIL %s enables at offset %0d: got %b expected %b", name, o, en, exp_en[o]);
            end
            n_checks++;
            if (done !== (o == exp_done)) begin
                n_fail++;
                $display("FAIL %s done at offset %0d: got %b expected %b", name, o, done, (o == exp_done));
            end
            n_checks++;
            if (busy !== (o <= exp_done)) begin
                n_fail++;
                $display("FAIL %s busy at offset %0d: got %b expected %b", name, o, busy, (o <= exp_done));
            end
            if (o == exp_done || o == exp_done + 1) begin
                n_checks++;
                if ({pass, fail_algo, aborted, timeout, error_count} !==
                    {exp_pass, exp_fail, exp_ab, exp_to, 4'(exp_cnt)}) begin
                    n_fail++;
                    $display("FAIL %s verdict at offset %0d: got pass=%b fail_algo=%b aborted=%b timeout=%b count=%0d expected pass=%b fail_algo=%b aborted=%b timeout=%b count=%0d",
                             name, o, pass, fail_algo, aborted, timeout, error_count,
                             exp_pass, exp_fail, exp_ab, exp_to, exp_cnt);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({marchc_en, marcha_en, apnpsf_en, busy, done, pass, fail_algo, aborted, timeout, error_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL %s outputs: got en=%b busy=%b done=%b pass=%b fail_algo=%b aborted=%b timeout=%b count=%0d expected all zero",
                     name, {apnpsf_en, marcha_en, marchc_en}, busy, done, pass, fail_algo, aborted, timeout, error_count);
        end
    endtask

    task automatic test_reset();
        noise = 0;
        set_cfg(5, 5, 5, -1, -1, -1, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_all_in_order();
        noise = 0;
        set_cfg(10, 10, 10, -1, -1, -1, 0, 0, 0);
        run_session(3'b111, "all_in_order");
    endtask

    task automatic test_single_errors();
        noise = 0;
        set_cfg(10, 8, 10, -1, -1, -1, 16'hFFFF, 16'b0000_0000_0100_1010, 16'hFFFF);
        run_session(3'b010, "single_errors");
    endtask

    task automatic test_abort_with_complete();
        noise = 0;
        set_cfg(5, 4, 6, 5, -1, -1, 0, 0, 0);
        run_session(3'b101, "abort_with_complete");
    endtask

    task automatic test_timeout();
        noise = 0;
        set_cfg(99, 3, 3, -1, -1, -1, 0, 0, 0);
        run_session(3'b011, "timeout");
    endtask

    task automatic test_saturation();
        noise = 0;
        set_cfg(10, 10, 10, -1, -1, -1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_session(3'b111, "saturation");
    endtask

    task automatic test_reset_mid_session();
        noise = 0;
        set_cfg(12, 12, 12, -1, -1, -1, 0, 0, 0);
        start = 1'b1; algo_sel = 3'b010;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (marcha_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid marcha_en before reset: got %b expected 1", marcha_en);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_immediate");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("reset_mid_held");
        end
        rst_n = 1'b1;
        set_cfg(3, 6, 3, -1, -1, -1, 0, 16'h0004, 0);
        run_session(3'b011, "after_reset");
    endtask

    task automatic test_back_to_back();
        noise = 1;
        set_cfg(6, 4, 7, -1, -1, -1, 0, 0, 0);
        run_session(3'b110, "busy_restart");
        run_session(3'b000, "empty_select");
        noise = 0;
        run_session(3'b000, "empty_quiet");
    endtask

    task automatic test_random();
        logic [2:0] sel;
        noise = 1;
        for (int s = 0; s < 25; s++) begin
            sel = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                dly[k]   = ($urandom % 6 == 0) ? 99 : int'($urandom_range(0, 14));
                abt[k]   = ($urandom % 4 == 0) ? int'($urandom_range(0, 14)) : -1;
                emask[k] = 16'($urandom & $urandom & $urandom);
            end
            run_session(sel, "random");
        end
    endtask

    initial begin
        test_reset();
        test_all_in_order();
        test_single_errors();
        test_abort_with_complete();
        test_timeout();
        test_saturation();
        test_reset_mid_session();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mbist_sequencer.md
MBIST_SEQUENCER -- requirements
Module: mbist_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the width of error_count.
REQ-002 Parameter WDOG_WIDTH, default 24, SHALL set the width of the per-algorithm watchdog counter.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a session start request, sampled in IDLE only.
REQ-006 algo_sel  input  3  SHALL select the algorithms: bit0 MarchC, bit1 MarchA, bit2 APNPSF; sampled with start.
REQ-007 marchc_en, marcha_en, apnpsf_en  output  1 each  SHALL be the registered, level enables to the decoder.
REQ-008 marchc_complete, marcha_complete, apnpsf_complete  input  1 each  SHALL be the decoder completion flags.
REQ-009 error  input  1  SHALL be the decoder per-cycle miscompare flag.
REQ-010 force_terminate  input  1  SHALL be the decoder abort request (allowable_faulty exceeded).
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 done  output  1  SHALL be a one-cycle pulse at session end.
REQ-013 pass  output  1  SHALL be the session verdict, valid from done until the next accepted start.
REQ-014 fail_algo  output  3  SHALL flag, per algo_sel bit position, each algorithm that saw at least one error.
REQ-015 aborted, timeout  output  1 each  SHALL flag termination by force_terminate or by the watchdog.
REQ-016 error_count  output  ADDR_WIDTH  SHALL hold the session error-cycle count.

Function
REQ-017 States SHALL be IDLE, SELECT, RUN and FINISH; encoding is free.
REQ-018 In IDLE, start=1 SHALL latch algo_sel into a pending mask, clear fail_algo, aborted, timeout, error_count and pass, and move to SELECT next cycle.
REQ-019 start SHALL be ignored in all states other than IDLE.
REQ-020 SELECT SHALL pick the lowest set pending bit (MarchC, then MarchA, then APNPSF), assert exactly that enable from the next cycle, clear the watchdog and enter RUN.
REQ-021 SELECT with an empty pending mask SHALL go to FINISH.
REQ-022 With start in cycle N and algo_sel!=0, the first enable SHALL be high in cycle N+2.
REQ-023 At most one enable SHALL be high in any cycle.
REQ-024 In RUN, the active enable SHALL stay high until the matching complete is sampled.
REQ-025 Complete flags of non-active algorithms SHALL be ignored.
REQ-026 Matching complete in cycle M SHALL drop the enable in M+1, clear that pending bit and return to SELECT.
REQ-027 The next enable SHALL therefore rise in M+2, or done SHALL pulse in M+2 if nothing is pending.
REQ-028 In every RUN cycle with error=1, error_count SHALL increment, saturating at all-ones, and the active algorithm's fail_algo bit SHALL set.
REQ-029 An error in the same cycle as complete SHALL be counted for the completing algorithm.
REQ-030 force_terminate=1 in RUN SHALL set aborted, drop the enable next cycle and go to FINISH, skipping remaining algorithms.
REQ-031 force_terminate SHALL take priority over a simultaneous complete.
REQ-032 error and force_terminate SHALL be ignored outside RUN.
REQ-033 The watchdog SHALL increment each RUN cycle.
REQ-034 When the watchdog reaches all-ones without complete, timeout SHALL set, the enable SHALL drop and the state SHALL go to FINISH.
REQ-035 FINISH SHALL assert done for one cycle with pass = (fail_algo==0) and not aborted and not timeout, then return to IDLE.
REQ-036 start with algo_sel=0 SHALL produce done in N+2 with pass=1.

Reset
REQ-037 On rst_n low, all enables, busy, done, pass, fail_algo, aborted, timeout, error_count, the pending mask and the watchdog SHALL go to 0 immediately, and the state SHALL go to IDLE.
REQ-038 Reset asserted mid-session SHALL abandon the session with no done pulse.
REQ-039 After reset release, the block SHALL accept start on the first clock edge.

Verification
REQ-040 algo_sel=3'b111, each complete 10 cycles after its enable, no errors -> enables fire in order MarchC, MarchA, APNPSF, one at a time, one-cycle gaps; done pulses once with pass=1 and error_count=0.
REQ-041 algo_sel=3'b010, error high for 3 RUN cycles -> only marcha_en toggles; fail_algo=3'b010, error_count=3, pass=0.
REQ-042 algo_sel=3'b101, force_terminate together with marchc_complete -> aborted=1; apnpsf_en never rises; done with pass=0.
REQ-043 WDOG_WIDTH=4, complete never arrives -> enable drops after 15 RUN cycles; timeout=1, pass=0.
REQ-044 rst_n pulsed low while marcha_en=1 -> all outputs 0 within the reset; no done; a new start then runs normally.
REQ-045 start re-pulsed while busy, and start with algo_sel=0 -> the first is ignored; the second gives done 2 cycles later with pass=1.
